fifo_control: RTL and testbench
===============================

// Module: fifo_control
// PURPOSE
//   Pointer/flag controller that sits directly upstream of the 8-entry memory
//   (memoria) and drives its write, read, ptr_write and ptr_read inputs.
//   - Turns push/pop requests into memory strobes and keeps the circular pointers.
//   - Tracks occupancy and raises full/empty/almost flags for the producer and consumer.
//   - Flags overflow and underflow in sticky error bits.
// PARAMETERS
//   LENGTH      8   number of memory entries; must equal 2**PTR_WIDTH
//   PTR_WIDTH   3   pointer width, matches the memory ptr_write/ptr_read ports
//   UMBRAL_ALTO 6   almost_full threshold; requires UMBRAL_BAJO < UMBRAL_ALTO <= LENGTH
//   UMBRAL_BAJO 2   almost_empty threshold
// PORTS
//   clk           in   1            single clock; all state updates on its rising edge
//   reset         in   1            synchronous, active-high reset
//   push          in   1            producer requests a write this cycle
//   pop           in   1            consumer requests a read this cycle
//   write         out  1            write strobe to memory
//   read          out  1            read strobe to memory
//   ptr_write     out  PTR_WIDTH    memory write address
//   ptr_read      out  PTR_WIDTH    memory read address
//   count         out  PTR_WIDTH+1  occupancy, range 0..LENGTH
//   full          out  1            count == LENGTH
//   empty         out  1            count == 0
//   almost_full   out  1            count >= UMBRAL_ALTO
//   almost_empty  out  1            count <= UMBRAL_BAJO
//   data_valid    out  1            memory data_out is valid this cycle
//   overflow      out  1            sticky: a push was rejected
//   underflow     out  1            sticky: a pop was rejected
// BEHAVIOUR
//   Reset (reset=1 sampled at the clk edge):
//     - ptr_write=0, ptr_read=0, count=0.
//     - empty=1, almost_empty=1, full=0, almost_full=0.
//     - data_valid=0, overflow=0, underflow=0.
//     - write and read are forced to 0 for the whole time reset is high.
//     - A reset in mid-operation discards all occupancy at that edge.
//   Strobes are combinational from the inputs and the registered flags:
//     - write = push & ~full & ~reset
//     - read  = pop  & ~empty & ~reset
//   Clock edge with a write: ptr_write <= ptr_write+1, wrapping from LENGTH-1 to 0.
//   Clock edge with a read:  ptr_read  <= ptr_read+1, with the same wrap.
//   Occupancy update per cycle:
//     - write only:  count +1
//     - read only:   count -1
//     - both:        count unchanged, both pointers advance
//     - neither:     no change
//   Flags are registered and derived from the next count value, so they are
//   valid in the same cycle as the updated count.
//   Boundary cases:
//     - push while full: no write, pointers held, overflow <= 1. If pop is also
//       high, the pop is still performed.
//     - pop while empty: no read, underflow <= 1. If push is also high, the write
//       is still performed and count becomes 1.
//   Sticky errors: overflow and underflow clear only on reset.
//   Read latency: data_valid <= read, one cycle after the strobe, aligned with
//   the memory's registered data_out.
//   No state machine beyond the pointer/count registers; there are no
//   combinational paths from push/pop to the flags.
// TESTING
//   1. Reset held 2 cycles with push=pop=1: write=read=0; ptrs=0, count=0,
//      empty=1, almost_empty=1.
//   2. 8 consecutive pushes: ptr_write steps 0..7 then wraps to 0; count=8;
//      almost_full rises after the 6th push; full=1 after the 8th; almost_empty
//      drops after the 3rd.
//   3. push=1 while full: write=0; ptr_write stays 0; count stays 8; overflow=1
//      and remains 1.
//   4. 8 pops from full: read high each cycle; ptr_read wraps 7->0; data_valid
//      high 1 cycle after each read; empty=1 at the end.
//   5. pop while empty -> underflow=1, read=0. At count=3, push&pop together:
//      count stays 3 and both ptrs +1.
//   6. count=5, assert reset for 1 cycle: next edge gives ptrs=0, count=0,
//      empty=1, overflow=underflow=0.

Source files
------------

// File: rtl/fifo_control.sv
// Pointer, occupancy and flag controller for an 8-entry circular memory.
// Turns push/pop requests into memory strobes, advances the circular pointers,
// keeps registered full/empty/almost flags and sticky overflow/underflow bits.
module fifo_control #(
  parameter int LENGTH      = 8,
  parameter int PTR_WIDTH   = 3,
  parameter int UMBRAL_ALTO = 6,
  parameter int UMBRAL_BAJO = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  output logic                 write,
  output logic                 read,
  output logic [PTR_WIDTH-1:0] ptr_write,
  output logic [PTR_WIDTH-1:0] ptr_read,
  output logic [PTR_WIDTH:0]   count,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 data_valid,
  output logic                 overflow,
  output logic                 underflow
);

  localparam logic [PTR_WIDTH-1:0] PTR_LAST  = PTR_WIDTH'(LENGTH - 1);
  localparam logic [PTR_WIDTH:0]   CNT_FULL  = (PTR_WIDTH+1)'(LENGTH);
  localparam logic [PTR_WIDTH:0]   CNT_ALTO  = (PTR_WIDTH+1)'(UMBRAL_ALTO);
  localparam logic [PTR_WIDTH:0]   CNT_BAJO  = (PTR_WIDTH+1)'(UMBRAL_BAJO);

  logic [PTR_WIDTH:0] count_next;

  // Circular increment with explicit wrap at the last memory entry.
  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    if (p == PTR_LAST) ptr_inc = '0;
    else               ptr_inc = p + 1'b1;
  endfunction

  // Strobes use only the registered flags, so push/pop never reach the flags combinationally.
  always_comb begin
    write = push & ~full  & ~reset;
    read  = pop  & ~empty & ~reset;
  end

  // Next occupancy: simultaneous read and write leaves the count unchanged.
  always_comb begin
    count_next = count;
    if (write && !read)      count_next = count + 1'b1;
    else if (read && !write) count_next = count - 1'b1;
  end

  // Pointers, occupancy, flags (from next count) and sticky error bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_write    <= '0;
      ptr_read     <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      data_valid   <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (write) ptr_write <= ptr_inc(ptr_write);
      if (read)  ptr_read  <= ptr_inc(ptr_read);
      count        <= count_next;
      full         <= (count_next == CNT_FULL);
      empty        <= (count_next == '0);
      almost_full  <= (count_next >= CNT_ALTO);
      almost_empty <= (count_next <= CNT_BAJO);
      // Memory data_out is registered, so valid lags the read strobe by one cycle.
      data_valid   <= read;
      if (push && full)  overflow  <= 1'b1;
      if (pop  && empty) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_control.sv
// Scoreboard bench for fifo_control: directed vectors push hand-computed
// expectations into a queue; a monitor pops and compares on each falling edge.
module tb_fifo_control;

  logic       clk = 1'b0;
  logic       reset, push, pop;
  logic       write, read;
  logic [2:0] ptr_write, ptr_read;
  logic [3:0] count;
  logic       full, empty, almost_full, almost_empty;
  logic       data_valid, overflow, underflow;

  typedef struct packed {
    logic       w;
    logic       r;
    logic [2:0] pw;
    logic [2:0] pr;
    logic [3:0] cnt;
    logic       fl;
    logic       em;
    logic       af;
    logic       ae;
    logic       dv;
    logic       ov;
    logic       un;
  } obs_t;

  obs_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   row      = 0;

  fifo_control dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .pop          (pop),
    .write        (write),
    .read         (read),
    .ptr_write    (ptr_write),
    .ptr_read     (ptr_read),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .data_valid   (data_valid),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  // Apply inputs for one cycle; expected values are the outputs seen during that
  // cycle: strobes for these inputs plus the state left by the previous edge.
  task automatic step(input logic rs, input logic pu, input logic po,
                      input logic w, input logic r,
                      input logic [2:0] pw, input logic [2:0] pr, input logic [3:0] cnt,
                      input logic fl, input logic em, input logic af, input logic ae,
                      input logic dv, input logic ov, input logic un);
    obs_t e;
    reset = rs; push = pu; pop = po;
    e = '{w:w, r:r, pw:pw, pr:pr, cnt:cnt, fl:fl, em:em, af:af, ae:ae, dv:dv, ov:ov, un:un};
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  // Monitor: compare every presented output cycle against the queued expectation.
  always @(negedge clk) begin
    obs_t a, e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{w:write, r:read, pw:ptr_write, pr:ptr_read, cnt:count, fl:full, em:empty,
            af:almost_full, ae:almost_empty, dv:data_valid, ov:overflow, un:underflow};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL row%0d: got w=%b r=%b pw=%0d pr=%0d cnt=%0d fl=%b em=%b af=%b ae=%b dv=%b ov=%b un=%b | want w=%b r=%b pw=%0d pr=%0d cnt=%0d fl=%b em=%b af=%b ae=%b dv=%b ov=%b un=%b",
                 row, a.w, a.r, a.pw, a.pr, a.cnt, a.fl, a.em, a.af, a.ae, a.dv, a.ov, a.un,
                 e.w, e.r, e.pw, e.pr, e.cnt, e.fl, e.em, e.af, e.ae, e.dv, e.ov, e.un);
      end
      row++;
    end
  end

  initial begin
    reset = 1'b1; push = 1'b1; pop = 1'b1;
    @(posedge clk); #1;
    //    rs pu po  w r  pw pr cnt   fl em af ae  dv ov un
    // Reset held with push=pop=1
    step(1, 1, 1,  0,0,  0, 0, 0,   0, 1, 0, 1,  0, 0, 0);
    step(1, 1, 1,  0,0,  0, 0, 0,   0, 1, 0, 1,  0, 0, 0);
    // Eight pushes
    step(0, 1, 0,  1,0,  0, 0, 0,   0, 1, 0, 1,  0, 0, 0);
    step(0, 1, 0,  1,0,  1, 0, 1,   0, 0, 0, 1,  0, 0, 0);
    step(0, 1, 0,  1,0,  2, 0, 2,   0, 0, 0, 1,  0, 0, 0);
    step(0, 1, 0,  1,0,  3, 0, 3,   0, 0, 0, 0,  0, 0, 0);
    step(0, 1, 0,  1,0,  4, 0, 4,   0, 0, 0, 0,  0, 0, 0);
    step(0, 1, 0,  1,0,  5, 0, 5,   0, 0, 0, 0,  0, 0, 0);
    step(0, 1, 0,  1,0,  6, 0, 6,   0, 0, 1, 0,  0, 0, 0);
    step(0, 1, 0,  1,0,  7, 0, 7,   0, 0, 1, 0,  0, 0, 0);
    // Push while full: rejected, overflow sticks
    step(0, 1, 0,  0,0,  0, 0, 8,   1, 0, 1, 0,  0, 0, 0);
    step(0, 1, 0,  0,0,  0, 0, 8,   1, 0, 1, 0,  0, 1, 0);
    // Push+pop while full: only the pop happens; then seven more pops
    step(0, 1, 1,  0,1,  0, 0, 8,   1, 0, 1, 0,  0, 1, 0);
    step(0, 0, 1,  0,1,  0, 1, 7,   0, 0, 1, 0,  1, 1, 0);
    step(0, 0, 1,  0,1,  0, 2, 6,   0, 0, 1, 0,  1, 1, 0);
    step(0, 0, 1,  0,1,  0, 3, 5,   0, 0, 0, 0,  1, 1, 0);
    step(0, 0, 1,  0,1,  0, 4, 4,   0, 0, 0, 0,  1, 1, 0);
    step(0, 0, 1,  0,1,  0, 5, 3,   0, 0, 0, 0,  1, 1, 0);
    step(0, 0, 1,  0,1,  0, 6, 2,   0, 0, 0, 1,  1, 1, 0);
    step(0, 0, 1,  0,1,  0, 7, 1,   0, 0, 0, 1,  1, 1, 0);
    // Pop while empty: rejected, underflow sticks
    step(0, 0, 1,  0,0,  0, 0, 0,   0, 1, 0, 1,  1, 1, 0);
    // Push+pop while empty: write still happens
    step(0, 1, 1,  1,0,  0, 0, 0,   0, 1, 0, 1,  0, 1, 1);
    step(0, 1, 0,  1,0,  1, 0, 1,   0, 0, 0, 1,  0, 1, 1);
    step(0, 1, 0,  1,0,  2, 0, 2,   0, 0, 0, 1,  0, 1, 1);
    // Count 3: push+pop together keeps count, both pointers advance
    step(0, 1, 1,  1,1,  3, 0, 3,   0, 0, 0, 0,  0, 1, 1);
    step(0, 0, 0,  0,0,  4, 1, 3,   0, 0, 0, 0,  1, 1, 1);
    step(0, 1, 0,  1,0,  4, 1, 3,   0, 0, 0, 0,  0, 1, 1);
    step(0, 1, 0,  1,0,  5, 1, 4,   0, 0, 0, 0,  0, 1, 1);
    // Count 5: one-cycle reset with push high clears everything
    step(1, 1, 0,  0,0,  6, 1, 5,   0, 0, 0, 0,  0, 1, 1);
    step(0, 0, 0,  0,0,  0, 0, 0,   0, 1, 0, 1,  0, 0, 0);
    step(0, 0, 1,  0,0,  0, 0, 0,   0, 1, 0, 1,  0, 0, 0);
    step(0, 0, 0,  0,0,  0, 0, 0,   0, 1, 0, 1,  0, 0, 1);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
